// File: rtl/sample_counter_multi.sv
// sample_counter_multi: a bank of independent sample-address counters.
// Each channel plays through 0..len-1, advancing on the shared en tick.
// It either stops at the end (one-shot) or wraps back to 0 (loop), and
// pulses done for one clock at every end-of-sample.
module sample_counter_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned AW       = 18
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   en,
    input  logic [CHANNELS-1:0]    go,
    input  logic [CHANNELS-1:0]    stop,
    input  logic [CHANNELS-1:0]    loop,
    input  logic [CHANNELS*AW-1:0] len,
    output logic [CHANNELS*AW-1:0] count,
    output logic [CHANNELS-1:0]    busy,
    output logic [CHANNELS-1:0]    done
);

    typedef enum logic {StIdle, StPlay} state_e;

    localparam logic [AW-1:0] One = AW'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_e        state_q, state_d;
        logic [AW-1:0] count_q, count_d;
        logic [AW-1:0] len_q, len_d;
        logic          done_q, done_d;
        logic [AW-1:0] len_in;
        logic          at_end;

        assign len_in = len[i*AW +: AW];
        // Latched length is never 0 while playing, so len_q - 1 cannot underflow there.
        assign at_end = (count_q == len_q - One);

        // Next-state: stop beats go, go beats the en-driven advance.
        always_comb begin
            state_d = state_q;
            count_d = count_q;
            len_d   = len_q;
            done_d  = 1'b0;
            if (stop[i]) begin
                state_d = StIdle;
                count_d = '0;
            end else if (go[i] && (len_in != '0)) begin
                state_d = StPlay;
                count_d = '0;
                len_d   = len_in;
            end else if ((state_q == StPlay) && en) begin
                if (at_end) begin
                    count_d = '0;
                    done_d  = 1'b1;
                    if (!loop[i]) begin
                        state_d = StIdle;
                    end
                end else begin
                    count_d = count_q + One;
                end
            end
        end

        // Channel state register; reset drops everything without a done pulse.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= StIdle;
                count_q <= '0;
                len_q   <= '0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                len_q   <= len_d;
                done_q  <= done_d;
            end
        end

        assign count[i*AW +: AW] = count_q;
        assign busy[i]           = (state_q == StPlay);
        assign done[i]           = done_q;
    end

endmodule
